// File: rtl/wb_slave_mux.sv
// N-channel Wishbone decode/gating mux, registered response (slave ack at t -> master ack at t+1), timeout watchdog, sticky faults.
// Master holds stb until ack (no other backpressure); optional status register under `WB_MUX_STATUS_EN`.
module wb_slave_mux #(
  parameter int                  N_SLV       = 6,
  parameter int                  DW          = 32,
  parameter int                  AW          = 32,
  parameter logic [N_SLV*AW-1:0] SLV_BASE    = {N_SLV{32'h3000_0000}},
  parameter logic [N_SLV*AW-1:0] SLV_MASK    = {N_SLV{32'hFFFF_F000}},
  parameter int                  TIMEOUT_CYC = 255,
  parameter logic [DW-1:0]       ERR_DATA    = 32'hDEAD_BEEF
`ifdef WB_MUX_STATUS_EN
  , parameter logic [AW-1:0]     STATUS_ADDR = 32'h3000_FF00
`endif
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [AW-1:0]       wbs_adr_i,
  input  logic [DW-1:0]       wbs_dat_i,
  output logic                wbs_ack_o,
  output logic [DW-1:0]       wbs_dat_o,
  output logic [N_SLV-1:0]    s_cyc_o,
  output logic [N_SLV-1:0]    s_stb_o,
  input  logic [N_SLV-1:0]    s_ack_i,
  input  logic [N_SLV*DW-1:0] s_dat_i,
  output logic [2:0]          err_o,
  input  logic                err_clr_i
);

  localparam int SW = (N_SLV > 1) ? $clog2(N_SLV) : 1;
  localparam int CW = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     sel_q, hit_idx;
  logic              hit_any, req, sel_ack, tmo, status_hit, status_clr;
  logic [N_SLV-1:0]  sel_oh, busy_oh;
  logic [DW-1:0]     sel_dat, resp_q, status_word;
  logic [CW-1:0]     cnt_q;
  logic [2:0]        err_q, err_set;

  // Slaves see sel and write data straight from the master.
  logic unused_ok;
  assign unused_ok = ^{wbs_sel_i, wbs_dat_i};

  assign req = wbs_cyc_i & wbs_stb_i;
  assign tmo = (cnt_q == CW'(TIMEOUT_CYC - 1));

  // Scan downwards so the lowest-index hit is the one left standing.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if ((wbs_adr_i & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
        hit_any = 1'b1;
        hit_idx = SW'(i);
      end
    end
  end

  always_comb begin
    sel_oh  = '0;
    sel_dat = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (sel_q == SW'(i)) begin
        sel_oh[i] = 1'b1;
        sel_dat   = s_dat_i[i*DW +: DW];
      end
    end
  end

  assign busy_oh = (state_q == BUSY) ? sel_oh : '0;
  assign sel_ack = |(s_ack_i & sel_oh);

`ifdef WB_MUX_STATUS_EN
  logic [3:0] fault_chan_q;
  assign status_hit  = (wbs_adr_i == STATUS_ADDR);
  assign status_word = DW'({16'b0, fault_chan_q, 9'b0, err_q});

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i)
      fault_chan_q <= '0;
    else if (err_set[1])
      fault_chan_q <= 4'(sel_q);
    else if (err_set[0])
      fault_chan_q <= 4'hF;
  end
`else
  assign status_hit  = 1'b0;
  assign status_word = '0;
`endif

  assign status_clr = (state_q == IDLE) & req & status_hit & wbs_we_i & wbs_dat_i[0];

  assign err_set[0] = (state_q == IDLE) & req & ~status_hit & ~hit_any;
  assign err_set[1] = (state_q == BUSY) & wbs_cyc_i & ~sel_ack & tmo;
  assign err_set[2] = |(s_ack_i & ~busy_oh);

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req) state_d = (status_hit || !hit_any) ? RESP : BUSY;
      BUSY: begin
        if (!wbs_cyc_i)         state_d = IDLE;
        else if (sel_ack || tmo) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wbs_ack_o = (state_q == RESP);
    wbs_dat_o = (state_q == RESP) ? resp_q : '0;
    s_cyc_o   = wbs_cyc_i ? busy_oh : '0;
    s_stb_o   = wbs_stb_i ? busy_oh : '0;
    err_o     = err_q;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      sel_q  <= '0;
      cnt_q  <= '0;
      resp_q <= '0;
      err_q  <= '0;
    end else begin
      if (state_q == IDLE && req) begin
        sel_q <= hit_idx;
        cnt_q <= '0;
        if (status_hit)
          resp_q <= wbs_we_i ? '0 : status_word;
        else if (!hit_any)
          resp_q <= ERR_DATA;
      end
      if (state_q == BUSY) begin
        cnt_q <= cnt_q + CW'(1);
        if (sel_ack)
          resp_q <= wbs_we_i ? '0 : sel_dat;
        else if (tmo)
          resp_q <= ERR_DATA;
      end
      // A fault raised in the clearing cycle survives the clear.
      err_q <= (err_q & ~{3{err_clr_i | status_clr}}) | err_set;
    end
  end

endmodule
